// File: rtl/nap_pkg.sv
// rtl/nap_pkg.sv - shared state encoding and digit defaults for the nap timer blocks
package nap_pkg;

    // Controller state encoding, also decoded by the display/alarm block
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    // Digit geometry shared with the display block
    localparam int DIGW_DEF    = 4;
    localparam int DIG_MAX_DEF = 9;

    // True when the state keeps the countdown alive (drives busy)
    function automatic logic is_active(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_PAUSED);
    endfunction

endpackage

// File: rtl/nap_digit_dec.sv
// rtl/nap_digit_dec.sv - one decimal digit of the ripple-borrow decrementer
module nap_digit_dec
    import nap_pkg::*;
#(
    parameter int DIGW    = DIGW_DEF,
    parameter int DIG_MAX = DIG_MAX_DEF
) (
    input  logic [DIGW-1:0] digit_in,
    input  logic            borrow_in,
    output logic [DIGW-1:0] digit_out,
    output logic            borrow_out
);

    localparam logic [DIGW-1:0] MAX_VAL = DIGW'(DIG_MAX);
    localparam logic [DIGW-1:0] ONE     = DIGW'(1);

    // A zero digit wraps to DIG_MAX and passes the borrow upward; any other digit absorbs it
    always_comb begin
        digit_out  = digit_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit_in == '0) begin
                digit_out  = MAX_VAL;
                borrow_out = 1'b1;
            end else begin
                digit_out  = digit_in - ONE;
            end
        end
    end

endmodule

// File: rtl/nap_countdown_ctrl.sv
// rtl/nap_countdown_ctrl.sv - nap timer sequencer: load, prescaled decimal countdown, expiry flag
module nap_countdown_ctrl
    import nap_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int DIGW     = DIGW_DEF,
    parameter int DIG_MAX  = DIG_MAX_DEF,
    parameter int TICK_DIV = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 clear,
    input  logic [NDIG*DIGW-1:0] load_val,
    output logic [NDIG*DIGW-1:0] count,
    output logic                 busy,
    output logic                 done,
    output logic                 alarm
);

    localparam int CW = NDIG * DIGW;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    logic [1:0]    state;
    logic [PW-1:0] prescaler;

    logic [1:0]    next_state;
    logic [CW-1:0] next_count;
    logic [PW-1:0] next_prescaler;
    logic          next_done;
    logic          next_alarm;

    logic [CW-1:0] dec_count;
    logic [NDIG:0] borrow;

    // Top-digit borrow only fires from a zero count, which never decrements
    logic unused_top_borrow;
    assign unused_top_borrow = borrow[NDIG];

    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            nap_digit_dec #(
                .DIGW    (DIGW),
                .DIG_MAX (DIG_MAX)
            ) u_dec (
                .digit_in   (count[gi*DIGW +: DIGW]),
                .borrow_in  (borrow[gi]),
                .digit_out  (dec_count[gi*DIGW +: DIGW]),
                .borrow_out (borrow[gi+1])
            );
        end
    endgenerate

    // Next-state logic; clear outranks start, start outranks pause
    always_comb begin
        next_state     = state;
        next_count     = count;
        next_prescaler = prescaler;
        next_done      = 1'b0;
        next_alarm     = alarm;
        if (clear) begin
            next_state     = ST_IDLE;
            next_count     = '0;
            next_prescaler = '0;
            next_alarm     = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_EXPIRED: begin
                    if (start) begin
                        next_count     = load_val;
                        next_prescaler = '0;
                        next_alarm     = 1'b0;
                        if (load_val != '0) begin
                            next_state = ST_RUN;
                        end else begin
                            // Nothing to count: expire straight away
                            next_state = ST_EXPIRED;
                            next_done  = 1'b1;
                            next_alarm = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        next_state = ST_PAUSED;
                    end else if (prescaler == PRE_LAST) begin
                        next_prescaler = '0;
                        next_count     = dec_count;
                        if (dec_count == '0) begin
                            next_state = ST_EXPIRED;
                            next_done  = 1'b1;
                            next_alarm = 1'b1;
                        end
                    end else begin
                        next_prescaler = prescaler + PRE_ONE;
                    end
                end
                ST_PAUSED: begin
                    // Prescaler keeps its value so the interrupted tick finishes after resume
                    if (!pause) begin
                        next_state = ST_RUN;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, prescaler and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            prescaler <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= next_state;
            count     <= next_count;
            prescaler <= next_prescaler;
            busy      <= is_active(next_state);
            done      <= next_done;
            alarm     <= next_alarm;
        end
    end

endmodule
